// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder slice used by the nibble-serial adder.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder streaming one nibble per clock through a single cla.
// Define NSA_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVF_EN
    ,output logic            ovf
`endif
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic [WIDTH-1:0]      op_a, op_b;
    logic [NIBBLE_W-1:0]   nib_sum;
    logic                  nib_cout;

    cla u_cla (
        .a    (op_a[idx*NIBBLE_W +: NIBBLE_W]),
        .b    (op_b[idx*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (idx == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // idx saturates at the last slice; leaving RUN resets it on the next accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry <= nib_cout;
                    if (idx != LAST) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cout = carry;

`ifdef NSA_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state_q == RUN && idx == LAST) begin
            ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (nib_sum[NIBBLE_W-1] != op_a[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NSA_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NSA_OVF_EN
        ,.ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Accept one operation, verify latency/result, stall `hold` cycles in DONE, then release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input int hold);
        logic [W:0]   full;
        logic [W-1:0] es;
        logic         ec;
        int           lat;
        full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
        es   = full[W-1:0];
        ec   = full[W];
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tcin; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = ~tb; cin = ~tcin;
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(N));
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
`ifdef NSA_OVF_EN
        chk("ovf", 32'(ovf), 32'((ta[W-1] == tb[W-1]) && (es[W-1] != ta[W-1])));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(sum), 32'(es));
            chk("hold_cout", 32'(cout), 32'(ec));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
`ifdef NSA_OVF_EN
        chk("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h00FF, 16'h0000, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 3);

        // Reset mid-RUN after two nibbles have been computed
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_sum", 32'(sum), 32'd0);
        chk("midreset_cout", 32'(cout), 32'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("midreset_no_stale", 32'(seen), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
